// File: rtl/mult_share_sched_pkg.sv
// mult_sched_pkg: shared types and defaults for the multiplier-sharing scheduler
package mult_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_TIMEOUT = 16;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mult_share_sched_if.sv
// mult_share_sched_if: client-side request/response bus of the scheduler
interface mult_share_sched_if
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH,
  localparam int ID_W = id_w(NUM_REQ)
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0] req_ready;
  logic rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic [2*WIDTH-1:0] rsp_product;
  logic rsp_err;
  modport master (
    output req_valid, req_a, req_b,
    input req_ready, rsp_valid, rsp_id, rsp_product, rsp_err
  );
  modport slave (
    input req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err
  );
endinterface

// File: rtl/mult_share_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting after last_grant
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);
  // Scan from lowest priority to highest so the nearest requester after the pointer wins last.
  always_comb begin
    grant = '0;
    grant_id = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (enable && req[ID_W'((int'(last_grant) + i) % NUM_REQ)]) begin
        grant = '0;
        grant[ID_W'((int'(last_grant) + i) % NUM_REQ)] = 1'b1;
        grant_id = ID_W'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler sharing one sequential multiplier engine
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int ID_W = id_w(NUM_REQ),
  localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  mult_share_sched_if.slave  bus,
  output logic               busy,
  output logic               eng_start,
  output logic [WIDTH-1:0]   eng_a,
  output logic [WIDTH-1:0]   eng_b,
  input  logic               eng_done,
  input  logic [2*WIDTH-1:0] eng_product
);
  state_t state, next;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] grant_id, id, last_grant;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0] rsp_id;
  logic [2*WIDTH-1:0] rsp_product;
  logic rsp_err;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) arb (
    .req(bus.req_valid),
    .last_grant(last_grant),
    .enable(state == IDLE && !rst),
    .grant(grant),
    .grant_id(grant_id)
  );

  always_ff @(posedge clk)
    state <= rst ? IDLE : next;

  // Done is checked before the timeout so a completion on the last allowed cycle still counts.
  always_comb begin
    next = state == IDLE ? (|grant ? ISSUE : IDLE)
         : state == ISSUE ? WAIT
         : state == WAIT ? ((eng_done || cnt == CNT_W'(TIMEOUT - 1)) ? RESP : WAIT)
         : IDLE;
    bus.req_ready = grant;
    bus.rsp_valid = state == RESP;
    bus.rsp_id = rsp_id;
    bus.rsp_product = rsp_product;
    bus.rsp_err = rsp_err;
    eng_start = state == ISSUE;
    busy = state != IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      cnt <= '0;
      eng_a <= '0;
      eng_b <= '0;
      rsp_id <= '0;
      rsp_product <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && |grant) begin
        id <= grant_id;
        eng_a <= bus.req_a[grant_id*WIDTH +: WIDTH];
        eng_b <= bus.req_b[grant_id*WIDTH +: WIDTH];
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) cnt <= cnt + 1'b1;
      if (state == WAIT && next == RESP) begin
        rsp_id <= id;
        rsp_product <= eng_done ? eng_product : '0;
        rsp_err <= !eng_done;
      end
      if (state == RESP) last_grant <= id;
    end
  end
endmodule

// File: tb/tb_mult_share_sched.sv
// tb_mult_share_sched: scoreboard bench with a fixed-latency engine model
module tb_mult_share_sched;
  localparam int N = 4;
  localparam int W = 4;
  localparam int TO = 16;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] prod;
    logic err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, eng_start, eng_done;
  logic extra_done = 1'b0;
  logic eng_en = 1'b1;
  logic [W-1:0] eng_a, eng_b;
  logic [2*W-1:0] eng_product = '0;
  int lat = 4;
  int ecnt = -1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int ngrant = 0;
  int nrsp = 0;
  int acc_cyc = 0;
  int start_cyc = 0;
  int rsp_cyc = 0;
  int rc[N];
  int gq[$];
  exp_t sq[$];

  always #5 clk = ~clk;

  mult_share_sched_if #(.NUM_REQ(N), .WIDTH(W)) bus();

  mult_share_sched #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .eng_start(eng_start),
    .eng_a(eng_a),
    .eng_b(eng_b),
    .eng_done(eng_done),
    .eng_product(eng_product)
  );

  // engine model: done pulse lat cycles after the start pulse, independent of rst
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_start) begin
      ecnt <= lat - 1;
      eng_product <= eng_a * eng_b;
    end else if (ecnt >= 0) ecnt <= ecnt - 1;
  end
  assign eng_done = (eng_en && ecnt == 0) || extra_done;

  always @(negedge clk) begin
    exp_t e;
    if (|bus.req_ready) begin
      checks++;
      if (!$onehot(bus.req_ready)) begin
        failures++;
        $display("FAIL ready_onehot got=%b want=one-hot", bus.req_ready);
      end
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) begin gq.push_back(i); rc[i]++; end
      ngrant++;
      acc_cyc = cyc;
    end
    if (eng_start) start_cyc = cyc;
    if (bus.rsp_valid) begin
      rsp_cyc = cyc;
      nrsp++;
      checks++;
      if (sq.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got id=%0d prod=%0d err=%0d want=no response",
                 bus.rsp_id, bus.rsp_product, bus.rsp_err);
      end else begin
        e = sq.pop_front();
        if ({bus.rsp_id, bus.rsp_product, bus.rsp_err} !== e) begin
          failures++;
          $display("FAIL rsp_data got id=%0d prod=%0d err=%0d want id=%0d prod=%0d err=%0d",
                   bus.rsp_id, bus.rsp_product, bus.rsp_err, e.id, e.prod, e.err);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic wait_grant(input int target, output bit ok);
    for (int k = 0; k < 200 && ngrant < target; k++) step(1);
    ok = ngrant >= target;
  endtask

  task automatic wait_rsp(input int target, output bit ok);
    for (int k = 0; k < 200 && nrsp < target; k++) step(1);
    ok = nrsp >= target;
  endtask

  task automatic test_reset;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    rst = 1'b1;
    step(3);
    checks++;
    if ({busy, eng_start, bus.rsp_valid, bus.req_ready, bus.rsp_id, bus.rsp_product,
         bus.rsp_err, eng_a, eng_b} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b start=%b rsp_valid=%b ready=%b prod=%h want all zero",
               busy, eng_start, bus.rsp_valid, bus.req_ready, bus.rsp_product);
    end
    rst = 1'b0;
    step(2);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_single;
    bit ok;
    int g0 = ngrant;
    int r0 = nrsp;
    set_op(0, 3, 2);
    sq.push_back({2'd0, 8'd6, 1'b0});
    bus.req_valid[0] = 1'b1;
    wait_grant(g0 + 1, ok);
    bus.req_valid[0] = 1'b0;
    checks++;
    if (!ok || gq[g0] != 0) begin failures++; $display("FAIL single_grant got ok=%b want granted id 0", ok); end
    wait_rsp(r0 + 1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_rsp_timeout got=none want=response"); end
    checks++;
    if (start_cyc - acc_cyc != 1) begin
      failures++;
      $display("FAIL single_start_lat got=%0d want=1", start_cyc - acc_cyc);
    end
    checks++;
    if (rsp_cyc - acc_cyc != 6) begin
      failures++;
      $display("FAIL single_rsp_lat got=%0d want=6", rsp_cyc - acc_cyc);
    end
  endtask

  task automatic test_all_four;
    bit ok;
    int g0, gi, r0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    foreach (rc[i]) rc[i] = 0;
    set_op(0, 3, 2); set_op(1, 4, 2); set_op(2, 15, 15); set_op(3, 0, 9);
    sq.push_back({2'd0, 8'd6, 1'b0});
    sq.push_back({2'd1, 8'd8, 1'b0});
    sq.push_back({2'd2, 8'd225, 1'b0});
    sq.push_back({2'd3, 8'd0, 1'b0});
    g0 = ngrant;
    gi = g0;
    r0 = nrsp;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 300 && ngrant < g0 + 4; k++) begin
      step(1);
      while (gi < ngrant) begin bus.req_valid[gq[gi]] = 1'b0; gi++; end
    end
    checks++;
    if (ngrant != g0 + 4) begin failures++; $display("FAIL all4_grants got=%0d want=4", ngrant - g0); end
    for (int i = 0; i < ngrant - g0 && i < 4; i++) begin
      checks++;
      if (gq[g0+i] != i) begin failures++; $display("FAIL all4_order slot=%0d got=%0d want=%0d", i, gq[g0+i], i); end
    end
    wait_rsp(r0 + 4, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL all4_rsp got=%0d want=4", nrsp - r0); end
    step(2);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rc[i] != 1) begin failures++; $display("FAIL all4_ready_pulses id=%0d got=%0d want=1", i, rc[i]); end
    end
  endtask

  task automatic test_fairness;
    bit ok;
    int ord[8] = '{1, 3, 1, 3, 1, 3, 0, 1};
    int g0 = ngrant;
    int r0 = nrsp;
    set_op(1, 5, 6); set_op(3, 7, 9); set_op(0, 2, 2);
    for (int i = 0; i < 8; i++)
      sq.push_back({2'(ord[i]), ord[i] == 1 ? 8'd30 : ord[i] == 3 ? 8'd63 : 8'd4, 1'b0});
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 600 && ngrant < g0 + 8; k++) begin
      step(1);
      if (ngrant >= g0 + 5) bus.req_valid[0] = 1'b1;
    end
    bus.req_valid = '0;
    checks++;
    if (ngrant != g0 + 8) begin failures++; $display("FAIL fair_grants got=%0d want=8", ngrant - g0); end
    for (int i = 0; i < ngrant - g0 && i < 8; i++) begin
      checks++;
      if (gq[g0+i] != ord[i]) begin
        failures++;
        $display("FAIL fair_order slot=%0d got=%0d want=%0d", i, gq[g0+i], ord[i]);
      end
    end
    wait_rsp(r0 + 8, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fair_rsp got=%0d want=8", nrsp - r0); end
  endtask

  task automatic test_timeout;
    bit ok;
    int g0 = ngrant;
    int r0 = nrsp;
    eng_en = 1'b0;
    set_op(2, 5, 5);
    sq.push_back({2'd2, 8'd0, 1'b1});
    bus.req_valid[2] = 1'b1;
    wait_grant(g0 + 1, ok);
    bus.req_valid[2] = 1'b0;
    wait_rsp(r0 + 1, ok);
    checks++;
    if (!ok || rsp_cyc - acc_cyc != TO + 2) begin
      failures++;
      $display("FAIL timeout_lat got=%0d want=%0d", rsp_cyc - acc_cyc, TO + 2);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy_drop got=%b want=0", busy); end
    eng_en = 1'b1;
  endtask

  task automatic test_done_edge;
    bit ok;
    int g0 = ngrant;
    int r0 = nrsp;
    lat = TO;
    set_op(0, 3, 5);
    sq.push_back({2'd0, 8'd15, 1'b0});
    bus.req_valid[0] = 1'b1;
    wait_grant(g0 + 1, ok);
    bus.req_valid[0] = 1'b0;
    wait_rsp(r0 + 1, ok);
    checks++;
    if (!ok || rsp_cyc - acc_cyc != TO + 2) begin
      failures++;
      $display("FAIL edge_lat got=%0d want=%0d", rsp_cyc - acc_cyc, TO + 2);
    end
    lat = 4;
    step(2);
    extra_done = 1'b1;
    step(1);
    extra_done = 1'b0;
    step(4);
    checks++;
    if (nrsp != r0 + 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL late_done_ignored got rsps=%0d busy=%b want rsps=1 busy=0", nrsp - r0, busy);
    end
    checks++;
    if (bus.rsp_product !== 8'd15) begin
      failures++;
      $display("FAIL rsp_hold got=%0d want=15", bus.rsp_product);
    end
  endtask

  task automatic test_rst_wait;
    bit ok;
    int g0 = ngrant;
    int r0 = nrsp;
    set_op(3, 9, 9);
    bus.req_valid[3] = 1'b1;
    wait_grant(g0 + 1, ok);
    bus.req_valid[3] = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if ({busy, eng_start, bus.rsp_valid, bus.req_ready, bus.rsp_id, bus.rsp_product,
         bus.rsp_err, eng_a, eng_b} !== '0) begin
      failures++;
      $display("FAIL rst_wait_outputs got busy=%b prod=%h a=%h b=%h want all zero",
               busy, bus.rsp_product, eng_a, eng_b);
    end
    step(8);
    checks++;
    if (nrsp != r0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_no_rsp got rsps=%0d busy=%b want rsps=0 busy=0", nrsp - r0, busy);
    end
    g0 = ngrant;
    set_op(0, 1, 1); set_op(1, 2, 3);
    sq.push_back({2'd0, 8'd1, 1'b0});
    sq.push_back({2'd1, 8'd6, 1'b0});
    bus.req_valid = 4'b0011;
    for (int k = 0; k < 200 && ngrant < g0 + 2; k++) begin
      step(1);
      if (ngrant > g0) bus.req_valid[gq[g0]] = 1'b0;
      if (ngrant > g0 + 1) bus.req_valid[gq[g0+1]] = 1'b0;
    end
    bus.req_valid = '0;
    checks++;
    if (ngrant < g0 + 1 || gq[g0] != 0) begin
      failures++;
      $display("FAIL rst_ptr_first got=%0d want=0", ngrant > g0 ? gq[g0] : -1);
    end
    wait_rsp(r0 + 2, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_after_rsp got=%0d want=2", nrsp - r0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_timeout();
    test_done_edge();
    test_rst_wait();
    step(3);
    checks++;
    if (sq.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d want=0", sq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Shares one sequential shift-add multiplier engine between NUM_REQ requesters.
- Arbitrates requests round-robin, latches the winner's operands and issues a one-cycle start to the engine.
- Waits for the engine's done, with a timeout watchdog, then returns the product tagged with the requester id.
- Sits between the client blocks and the single multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width; product is 2*WIDTH.
- TIMEOUT, 16, max cycles in WAIT before abort (>= engine latency + 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request, level, held until accepted.
- req_a  in  NUM_REQ*WIDTH  packed operand A; slice i belongs to requester i.
- req_b  in  NUM_REQ*WIDTH  packed operand B.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  clog2(NUM_REQ)  requester the response belongs to.
- rsp_product  out  2*WIDTH  result; zero on error.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- busy  out  1  high in every state except IDLE.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_a, eng_b  out  WIDTH  operands to the engine; held stable from ISSUE through WAIT.
- eng_done  in  1  engine completion pulse.
- eng_product  in  2*WIDTH  engine result, sampled on eng_done.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State = IDLE.
  - All outputs = 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Timeout counter = 0.
  - rst mid-operation aborts the transaction with no response; the engine may still pulse eng_done afterwards, and that pulse is ignored.
- IDLE:
  - If any req_valid is set, grant = first set bit searching last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ).
  - Assert req_ready[grant] this cycle. Latch a/b slices and id. Go to ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE:
  - eng_start=1 for exactly one cycle; eng_a/eng_b = latched values.
  - Clear the counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On eng_done: latch eng_product, err=0, go to RESP.
  - Else, when counter == TIMEOUT-1: product=0, err=1, go to RESP.
  - eng_done arriving in the same cycle as the timeout: done wins, err=0.
- RESP:
  - rsp_valid=1 for one cycle with rsp_id, rsp_product, rsp_err.
  - last_grant = id. Go to IDLE.
- Outputs outside RESP:
  - rsp_valid=0; rsp_id, rsp_product, rsp_err hold their last values.
- eng_done outside WAIT is ignored (stale or spurious).
- Latency:
  - Accept at cycle T; eng_start at T+1.
  - Engine done at T+1+k; rsp_valid at T+2+k.
  - Next accept no earlier than T+3+k.
  - No pipelining; at most one transaction is outstanding.
- req_valid deasserted before it is granted: no effect.
- Requester i is never granted twice while another requester j has been continuously valid. This bounds starvation to NUM_REQ-1 transactions.
- Arithmetic: pass-through only. The scheduler never computes or shortcuts a product (0 and max operands still go to the engine).

Decomposition:
- Package mult_sched_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}, 2-bit.
  - ID_W = clog2(NUM_REQ) helper.
  - Default WIDTH and TIMEOUT constants.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, last_grant, enable.
  - Outputs: one-hot grant and encoded grant_id.
  - Purely combinational. The pointer register lives in mult_share_sched.

Test Plan:
- Single request. Engine model has fixed 4-cycle latency (k=4). Req0 a=3, b=2 -> req_ready[0] at T, eng_start at T+1, rsp_valid at T+6 with id=0, product=8'd6, err=0.
- All four requesters valid from reset, operands (3,2), (4,2), (15,15), (0,9) -> responses in id order 0,1,2,3 with products 6, 8, 225, 0. Each req_ready is exactly one pulse.
- Fairness:
  - Req1 and req3 held valid continuously -> grants alternate 1,3,1,3.
  - Then req0 is added -> order continues 1,3,0,1 (pointer-based, not fixed priority).
- Timeout: engine model never asserts eng_done -> rsp_valid exactly TIMEOUT+2 cycles after accept, err=1, product=0. busy drops the following cycle.
- Done on the timeout edge: eng_done arrives on the cycle counter==TIMEOUT-1 -> err=0 and the product is taken from the engine. A late eng_done while in IDLE -> no rsp_valid.
- rst pulsed for one cycle during WAIT -> all outputs 0 next cycle, no rsp_valid, the pending eng_done is ignored, and the next request is served starting from requester 0.
